lift_dispatcher: RTL and testbench

//  Group-control dispatcher in front of NUM_CARS Lift8 cars: collects hall calls into a pending-floor bitmap.

---
 rtl/lift_pkg.sv | 23 ++
 rtl/lift_car_select.sv | 34 +++
 rtl/lift_dispatcher.sv | 159 +++++++++++++++
 tb/tb_lift_dispatcher.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared defaults, dispatcher FSM state type and the floor distance helper.
package lift_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2
  } disp_state_t;

  // Unsigned FLOOR_W+1-bit distance; no modular wrap between top and bottom floors.
  function automatic logic [FLOOR_W:0] floor_dist(input logic [FLOOR_W-1:0] a,
                                                  input logic [FLOOR_W-1:0] b);
    logic [FLOOR_W:0] wa;
    logic [FLOOR_W:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/lift_car_select.sv
// Combinational nearest-idle-car picker; ties resolve to the lowest car index.
module lift_car_select
  import lift_pkg::*;
#(
  parameter int NUM_CARS = 2,
  parameter int FLOOR_W  = lift_pkg::FLOOR_W
) (
  input  logic [NUM_CARS*FLOOR_W-1:0] i_car_floor,
  input  logic [NUM_CARS-1:0]         i_car_idle,
  input  logic [FLOOR_W-1:0]          i_target,
  output logic [1:0]                  o_sel_car,
  output logic                        o_any_idle
);

  logic [FLOOR_W:0] w_best;
  logic [FLOOR_W:0] w_dist;

  always_comb begin
    o_sel_car  = '0;
    o_any_idle = 1'b0;
    w_best     = '1;
    w_dist     = '0;
    for (int i = 0; i < NUM_CARS; i++) begin
      w_dist = floor_dist(i_car_floor[i*FLOOR_W +: FLOOR_W], i_target);
      // Strict less-than keeps the earlier (lower-index) car on equal distance.
      if (i_car_idle[i] && (!o_any_idle || (w_dist < w_best))) begin
        o_any_idle = 1'b1;
        w_best     = w_dist;
        o_sel_car  = 2'(i);
      end
    end
  end

endmodule

// File: rtl/lift_dispatcher.sv
// Group-control lift dispatcher: pending-call bitmap, round-robin floor scan, nearest-idle-car assignment.
// Defining LIFT_DISPATCH_EMERG_EN adds the emergency_stop input.
module lift_dispatcher
  import lift_pkg::*;
#(
  parameter int NUM_CARS    = 2,
  parameter int NUM_FLOORS  = lift_pkg::NUM_FLOORS,
  parameter int FLOOR_W     = lift_pkg::FLOOR_W,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset_n,
`ifdef LIFT_DISPATCH_EMERG_EN
  input  logic                        emergency_stop,
`endif
  input  logic                        call_valid,
  input  logic [FLOOR_W-1:0]          call_floor,
  output logic                        call_ready,
  input  logic [NUM_CARS*FLOOR_W-1:0] car_floor,
  input  logic [NUM_CARS-1:0]         car_idle,
  output logic [NUM_CARS-1:0]         asg_valid,
  output logic [FLOOR_W-1:0]          asg_floor,
  input  logic [NUM_CARS-1:0]         asg_ready,
  output logic [NUM_FLOORS-1:0]       pending,
  output logic                        busy,
  output disp_state_t                 dbg_state
);

  // Handshake: an assignment transfers on the edge where asg_valid[sel_car] and
  // asg_ready[sel_car] are both high; asg_floor is stable for the whole S_ISSUE stay.

  disp_state_t           r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [FLOOR_W-1:0]    r_ptr;
  logic [FLOOR_W-1:0]    r_asg_floor;
  logic [1:0]            r_sel_car;
  logic [3:0]            r_tmo;

  logic                  w_emerg;
  logic                  w_accept;
  logic                  w_ack;
  logic                  w_tmo_done;
  logic                  w_found;
  logic                  w_any_idle;
  logic [1:0]            w_sel_car;
  logic [FLOOR_W-1:0]    w_target;
  logic [FLOOR_W-1:0]    w_idx;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;

`ifdef LIFT_DISPATCH_EMERG_EN
  assign w_emerg = emergency_stop;
`else
  assign w_emerg = 1'b0;
`endif

  assign call_ready = ~w_emerg;
  assign w_accept   = call_valid & call_ready;

  always_comb begin
    w_ack     = 1'b0;
    asg_valid = '0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (r_sel_car == 2'(i)) begin
        w_ack        = (r_state == S_ISSUE) && asg_ready[i];
        asg_valid[i] = (r_state == S_ISSUE) && !w_emerg;
      end
    end
  end

  assign w_tmo_done = (r_state == S_ISSUE) && !w_ack && (r_tmo == 4'(ACK_TIMEOUT - 1));

  // Out-of-range call floors match no bit and are silently dropped.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      w_set[f] = w_accept && (call_floor == FLOOR_W'(f));
      w_clr[f] = w_ack && (r_asg_floor == FLOOR_W'(f));
    end
  end

  // Round-robin scan starts just above the last served floor so no floor starves.
  always_comb begin
    w_found  = 1'b0;
    w_target = r_ptr;
    w_idx    = '0;
    for (int k = 1; k <= NUM_FLOORS; k++) begin
      w_idx = FLOOR_W'((int'(r_ptr) + k) % NUM_FLOORS);
      if (!w_found && r_pending[w_idx]) begin
        w_found  = 1'b1;
        w_target = w_idx;
      end
    end
  end

  lift_car_select #(
    .NUM_CARS (NUM_CARS),
    .FLOOR_W  (FLOOR_W)
  ) u_car_select (
    .i_car_floor (car_floor),
    .i_car_idle  (car_idle),
    .i_target    (w_target),
    .o_sel_car   (w_sel_car),
    .o_any_idle  (w_any_idle)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_ptr       <= FLOOR_W'(NUM_FLOORS - 1);
      r_asg_floor <= '0;
      r_sel_car   <= '0;
      r_tmo       <= '0;
    end else if (w_emerg) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_tmo     <= '0;
    end else begin
      // Clear beats a same-edge set: a call for the floor being retired counts as served.
      r_pending <= (r_pending | w_set) & ~w_clr;
      case (r_state)
        S_IDLE: begin
          if ((|r_pending) && (|car_idle)) r_state <= S_SELECT;
        end
        S_SELECT: begin
          if (w_any_idle && w_found) begin
            r_sel_car   <= w_sel_car;
            r_asg_floor <= w_target;
            r_tmo       <= '0;
            r_state     <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (w_ack) begin
            r_ptr   <= r_asg_floor;
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else if (w_tmo_done) begin
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pending   = r_pending;
  assign asg_floor = r_asg_floor;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lift_dispatcher.sv
// Self-checking bench for lift_dispatcher: directed scenarios plus randomized calls against a floor/car model.
`timescale 1ns/1ps
module tb_lift_dispatcher;
  import lift_pkg::*;

  localparam int NC  = 2;
  localparam int NF  = 8;
  localparam int FW  = 3;
  localparam int TMO = 15;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            call_valid;
  logic [FW-1:0]   call_floor;
  logic            call_ready;
  logic [NC*FW-1:0] car_floor;
  logic [NC-1:0]   car_idle;
  logic [NC-1:0]   asg_valid;
  logic [FW-1:0]   asg_floor;
  logic [NC-1:0]   asg_ready;
  logic [NF-1:0]   pending;
  logic            busy;
  disp_state_t     dbg_state;
`ifdef LIFT_DISPATCH_EMERG_EN
  logic            emergency_stop;
`endif

  always #5 clk = ~clk;

  lift_dispatcher #(
    .NUM_CARS (NC), .NUM_FLOORS (NF), .FLOOR_W (FW), .ACK_TIMEOUT (TMO)
  ) dut (
    .clk (clk), .reset_n (reset_n),
`ifdef LIFT_DISPATCH_EMERG_EN
    .emergency_stop (emergency_stop),
`endif
    .call_valid (call_valid), .call_floor (call_floor), .call_ready (call_ready),
    .car_floor (car_floor), .car_idle (car_idle),
    .asg_valid (asg_valid), .asg_floor (asg_floor), .asg_ready (asg_ready),
    .pending (pending), .busy (busy), .dbg_state (dbg_state)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  logic [NF-1:0] m_pend;
  int            m_ptr;
  int            car_fl[NC];
  logic [FW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic int m_target();
    for (int k = 1; k <= NF; k++) begin
      if (m_pend[(m_ptr + k) % NF]) return (m_ptr + k) % NF;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] m_car(input int tgt);
    int            best;
    int            d;
    logic [NC-1:0] oh;
    best = 1000;
    oh   = '0;
    for (int i = 0; i < NC; i++) begin
      d = (car_fl[i] > tgt) ? car_fl[i] - tgt : tgt - car_fl[i];
      if (car_idle[i] && d < best) begin
        best = d;
        oh   = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cars(input int f0, input int f1, input logic [NC-1:0] idle);
    car_fl[0] = f0;
    car_fl[1] = f1;
    for (int i = 0; i < NC; i++) car_floor[i*FW +: FW] = FW'(car_fl[i]);
    car_idle = idle;
  endtask

  task automatic call(input int fl);
    call_valid = 1'b1;
    call_floor = FW'(fl);
    tick();
    call_valid = 1'b0;
    m_pend[fl] = 1'b1;
  endtask

  task automatic ack(input logic [NC-1:0] oh);
    int fl;
    fl = int'(asg_floor);
    asg_ready = oh;
    tick();
    asg_ready = '0;
    m_pend[fl] = 1'b0;
    m_ptr = fl;
  endtask

  task automatic wait_asg();
    int n;
    n = 0;
    while (asg_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (asg_valid == '0) begin
      n_err++;
      $display("FAIL wait_asg: asg_valid=%b after %0d cycles, required nonzero", asg_valid, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_cmp++; if (pending !== '0) begin n_err++; $display("FAIL reset_pending: got %h want 00", pending); end
    n_cmp++; if (asg_valid !== '0) begin n_err++; $display("FAIL reset_asg_valid: got %b want 00", asg_valid); end
    n_cmp++; if (asg_floor !== '0) begin n_err++; $display("FAIL reset_asg_floor: got %0d want 0", asg_floor); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (call_ready !== 1'b1) begin n_err++; $display("FAIL reset_call_ready: got %b want 1", call_ready); end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    tick();
    reset_n = 1'b1;
    m_pend = '0;
    m_ptr = NF - 1;
    // Pointer at the top floor after reset: floor 0 is scanned before floor 7.
    set_cars(3, 3, 2'b00);
    call(7);
    call(0);
    car_idle = 2'b11;
    wait_asg();
    n_cmp++; if (asg_floor !== 3'd0) begin n_err++; $display("FAIL reset_ptr_first: got %0d want 0", asg_floor); end
    ack(asg_valid);
    wait_asg();
    n_cmp++; if (asg_floor !== 3'd7) begin n_err++; $display("FAIL reset_ptr_second: got %0d want 7", asg_floor); end
    ack(asg_valid);
  endtask

  task automatic test_single_call();
    set_cars(0, 5, 2'b11);
    call(4);
    n_cmp++; if (pending !== 8'h10) begin n_err++; $display("FAIL single_pend: got %h want 10", pending); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy0: got %b want 0", busy); end
    tick();
    n_cmp++; if (busy !== 1'b1 || asg_valid !== 2'b00) begin n_err++; $display("FAIL single_select: busy=%b asg_valid=%b want 1/00", busy, asg_valid); end
    tick();
    n_cmp++; if (asg_valid !== 2'b10) begin n_err++; $display("FAIL single_asg_valid: got %b want 10", asg_valid); end
    n_cmp++; if (asg_floor !== 3'd4) begin n_err++; $display("FAIL single_asg_floor: got %0d want 4", asg_floor); end
    ack(2'b10);
    n_cmp++; if (pending !== 8'h00 || asg_valid !== 2'b00) begin n_err++; $display("FAIL single_done: pending=%h asg_valid=%b want 00/00", pending, asg_valid); end
  endtask

  task automatic test_tie();
    set_cars(2, 6, 2'b11);
    call(4);
    wait_asg();
    n_cmp++; if (asg_valid !== 2'b01) begin n_err++; $display("FAIL tie_low_index: got %b want 01", asg_valid); end
    ack(2'b01);
    set_cars(2, 6, 2'b10);
    call(4);
    wait_asg();
    n_cmp++; if (asg_valid !== 2'b10) begin n_err++; $display("FAIL tie_car0_busy: got %b want 10", asg_valid); end
    asg_ready = 2'b01;
    tick();
    tick();
    asg_ready = '0;
    n_cmp++; if (asg_valid !== 2'b10 || pending !== 8'h10) begin n_err++; $display("FAIL tie_wrong_ready: asg_valid=%b pending=%h want 10/10", asg_valid, pending); end
    ack(2'b10);
    set_cars(3, 4, 2'b11);
    call(4);
    wait_asg();
    n_cmp++; if (asg_valid !== 2'b10) begin n_err++; $display("FAIL tie_dist_zero: got %b want 10", asg_valid); end
    ack(2'b10);
  endtask

  task automatic test_ignored_ready();
    set_cars(0, 0, 2'b00);
    call(2);
    asg_ready = 2'b11;
    repeat (3) tick();
    asg_ready = '0;
    n_cmp++; if (pending !== m_pend || busy !== 1'b0 || asg_valid !== '0) begin n_err++; $display("FAIL idle_ready: pending=%h busy=%b asg_valid=%b want %h/0/00", pending, busy, asg_valid, m_pend); end
    car_idle = 2'b01;
    wait_asg();
    ack(2'b01);
  endtask

  task automatic test_fairness();
    logic [FW-1:0] e;
    set_cars(0, 7, 2'b11);
    call(3);
    wait_asg();
    ack(asg_valid);
    car_idle = 2'b00;
    call(1);
    call(6);
    call(3);
    n_cmp++; if (pending !== 8'b0100_1010) begin n_err++; $display("FAIL fair_pend: got %b want 01001010", pending); end
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    car_idle = 2'b11;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_asg();
      n_cmp++; if (asg_floor !== e) begin n_err++; $display("FAIL fair_order: got %0d want %0d", asg_floor, e); end
      ack(asg_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    set_cars(1, 1, 2'b11);
    call(2);
    wait_asg();
    n = 0;
    while (asg_valid != '0 && n < 40) begin
      n++;
      tick();
    end
    n_cmp++; if (n != TMO) begin n_err++; $display("FAIL timeout_len: got %0d want %0d", n, TMO); end
    n_cmp++; if (pending !== 8'h04) begin n_err++; $display("FAIL timeout_keep: got %h want 04", pending); end
    wait_asg();
    n_cmp++; if (asg_floor !== 3'd2) begin n_err++; $display("FAIL timeout_reissue: got %0d want 2", asg_floor); end
    ack(asg_valid);
    n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL timeout_clear: got %h want 00", pending); end
  endtask

  task automatic test_merge_race();
    set_cars(0, 0, 2'b01);
    call(4);
    wait_asg();
    asg_ready = 2'b01;
    call_valid = 1'b1;
    call_floor = 3'd4;
    tick();
    asg_ready = '0;
    call_valid = 1'b0;
    m_pend[4] = 1'b0;
    m_ptr = 4;
    n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL race_same_floor: got %h want 00", pending); end
    call(4);
    wait_asg();
    asg_ready = 2'b01;
    call_valid = 1'b1;
    call_floor = 3'd5;
    tick();
    asg_ready = '0;
    call_valid = 1'b0;
    m_pend = 8'h20;
    m_ptr = 4;
    n_cmp++; if (pending !== 8'h20) begin n_err++; $display("FAIL race_other_floor: got %h want 20", pending); end
    wait_asg();
    ack(asg_valid);
  endtask

  task automatic test_random();
    int            tgt;
    int            d;
    int            n;
    int            nc;
    logic [NC-1:0] oh;
    for (int it = 0; it < 30; it++) begin
      car_idle = '0;
      for (int i = 0; i < NC; i++) begin
        car_fl[i] = int'($urandom_range(0, NF - 1));
        car_floor[i*FW +: FW] = FW'(car_fl[i]);
      end
      nc = int'($urandom_range(1, 3));
      for (int j = 0; j < nc; j++) call(int'($urandom_range(0, NF - 1)));
      n_cmp++; if (pending !== m_pend) begin n_err++; $display("FAIL rnd_pend it%0d: got %h want %h", it, pending, m_pend); end
      car_idle = NC'($urandom_range(1, 3));
      wait_asg();
      tgt = m_target();
      oh  = m_car(tgt);
      n_cmp++; if (asg_floor !== FW'(tgt) || asg_valid !== oh) begin n_err++; $display("FAIL rnd_assign it%0d: floor=%0d car=%b want %0d/%b", it, asg_floor, asg_valid, tgt, oh); end
      d = int'($urandom_range(0, 17));
      if (d < TMO) begin
        for (int c = 0; c < d; c++) begin
          tick();
          n_cmp++; if (asg_floor !== FW'(tgt) || asg_valid !== oh) begin n_err++; $display("FAIL rnd_hold it%0d: floor=%0d car=%b want %0d/%b", it, asg_floor, asg_valid, tgt, oh); end
        end
        ack(oh | NC'($urandom_range(0, 3)));
        n_cmp++; if (pending !== m_pend || asg_valid !== '0) begin n_err++; $display("FAIL rnd_ack it%0d: pending=%h asg_valid=%b want %h/00", it, pending, asg_valid, m_pend); end
      end else begin
        n = 0;
        while (asg_valid != '0 && n < 40) begin
          n++;
          tick();
        end
        n_cmp++; if (n != TMO || pending !== m_pend) begin n_err++; $display("FAIL rnd_timeout it%0d: cycles=%0d pending=%h want %0d/%h", it, n, pending, TMO, m_pend); end
      end
    end
  endtask

`ifdef LIFT_DISPATCH_EMERG_EN
  task automatic test_emergency();
    set_cars(0, 0, 2'b01);
    call(2);
    wait_asg();
    emergency_stop = 1'b1;
    #1;
    n_cmp++; if (call_ready !== 1'b0 || asg_valid !== '0) begin n_err++; $display("FAIL emerg_comb: call_ready=%b asg_valid=%b want 0/00", call_ready, asg_valid); end
    tick();
    n_cmp++; if (pending !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL emerg_clear: pending=%h busy=%b want 00/0", pending, busy); end
    emergency_stop = 1'b0;
    m_pend = '0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_issue();
    set_cars(0, 0, 2'b01);
    call(1);
    call(6);
    wait_asg();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (asg_valid !== '0 || pending !== '0) begin n_err++; $display("FAIL midreset_outputs: asg_valid=%b pending=%h want 00/00", asg_valid, pending); end
    n_cmp++; if (busy !== 1'b0 || dbg_state !== S_IDLE) begin n_err++; $display("FAIL midreset_state: busy=%b state=%0d want 0/%0d", busy, dbg_state, S_IDLE); end
    tick();
    reset_n = 1'b1;
    m_pend = '0;
    m_ptr = NF - 1;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    call_valid = 1'b0;
    call_floor = '0;
    car_floor  = '0;
    car_idle   = '0;
    asg_ready  = '0;
    m_pend     = '0;
    m_ptr      = NF - 1;
`ifdef LIFT_DISPATCH_EMERG_EN
    emergency_stop = 1'b0;
`endif
    test_reset();
    test_single_call();
    test_tie();
    test_ignored_ready();
    test_fairness();
    test_timeout();
    test_merge_race();
    test_random();
`ifdef LIFT_DISPATCH_EMERG_EN
    test_emergency();
`endif
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
